// File: rtl/trivium_pkg.sv
// Shared types and constants for the Trivium receive-side decrypt path.
package trivium_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned DEF_DEPTH = 8;
    localparam int unsigned DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        REINIT,
        WAIT,
        RUN
    } state_t;

endpackage

// File: rtl/trivium_stream_decrypt_byte_fifo.sv
// Single-clock byte FIFO with a first-word-fall-through head.
// Pointers carry an extra MSB so that full and empty can be told apart.
module byte_fifo
    import trivium_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [BYTE_W-1:0]        din,
    input  logic                     pop,
    output logic [BYTE_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic [BYTE_W-1:0] mem [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign level   = wptr - rptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Head reads as zero while empty so the plaintext port idles at a known value.
    assign dout    = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/trivium_stream_decrypt.sv
// Receive-side Trivium decrypt: XORs ciphertext with keystream into a plaintext
// FIFO and owns keystream resynchronisation (reinit pulse, then wait for valid).
module trivium_stream_decrypt
    import trivium_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [BYTE_W-1:0]        ct_data,
    input  logic                     ct_valid,
    output logic                     ct_ready,
    input  logic [BYTE_W-1:0]        ks_byte,
    input  logic                     ks_valid,
    output logic                     ks_ready,
    output logic                     ks_reinit,
    input  logic                     resync,
    output logic [BYTE_W-1:0]        pt_data,
    output logic                     pt_valid,
    input  logic                     pt_ready,
    output logic [CNT_W-1:0]         byte_count,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     busy
);

    state_t state;
    logic   fifo_full;
    logic   fifo_empty;
    logic   xfer;

    // Full is checked without regard to a same-cycle pop.
    assign ct_ready  = (state == RUN) && ks_valid && !fifo_full;
    assign xfer      = ct_valid && ct_ready;
    assign ks_ready  = xfer;
    assign ks_reinit = (state == REINIT);
    assign busy      = (state != RUN);
    assign pt_valid  = !fifo_empty;

    byte_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (xfer),
        .din  (ct_data ^ ks_byte),
        .pop  (pt_ready),
        .dout (pt_data),
        .full (fifo_full),
        .empty(fifo_empty),
        .level(fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WAIT;
            byte_count <= '0;
        end else begin
            if (state == REINIT)
                byte_count <= '0;
            else if (xfer)
                byte_count <= byte_count + CNT_W'(1);

            if (resync) begin
                state <= REINIT;
            end else begin
                case (state)
                    REINIT:  state <= WAIT;
                    WAIT:    if (ks_valid) state <= RUN;
                    default: state <= state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trivium_stream_decrypt.sv
// Self-checking bench: vector table, directed corner sequences and a random
// phase, all compared every cycle against a queue-based behavioural model.
module tb_trivium_stream_decrypt;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;
    localparam int M_REINIT = 0;
    localparam int M_WAIT   = 1;
    localparam int M_RUN    = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       ct_data;
    logic             ct_valid;
    logic             ct_ready;
    logic [7:0]       ks_byte;
    logic             ks_valid;
    logic             ks_ready;
    logic             ks_reinit;
    logic             resync;
    logic [7:0]       pt_data;
    logic             pt_valid;
    logic             pt_ready;
    logic [CNT_W-1:0] byte_count;
    logic [LW-1:0]    fifo_level;
    logic             busy;

    logic             w4_ct_ready, w4_ks_ready, w4_ks_reinit, w4_pt_valid, w4_busy;
    logic [7:0]       w4_pt_data;
    logic [3:0]       w4_byte_count;
    logic [LW-1:0]    w4_fifo_level;

    always #5 clk = ~clk;

    trivium_stream_decrypt #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .ct_data(ct_data), .ct_valid(ct_valid), .ct_ready(ct_ready),
        .ks_byte(ks_byte), .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_reinit(ks_reinit),
        .resync(resync), .pt_data(pt_data), .pt_valid(pt_valid), .pt_ready(pt_ready),
        .byte_count(byte_count), .fifo_level(fifo_level), .busy(busy)
    );

    trivium_stream_decrypt #(.DEPTH(DEPTH), .CNT_W(4)) dut_w4 (
        .clk(clk), .rst(rst), .ct_data(ct_data), .ct_valid(ct_valid), .ct_ready(w4_ct_ready),
        .ks_byte(ks_byte), .ks_valid(ks_valid), .ks_ready(w4_ks_ready), .ks_reinit(w4_ks_reinit),
        .resync(resync), .pt_data(w4_pt_data), .pt_valid(w4_pt_valid), .pt_ready(pt_ready),
        .byte_count(w4_byte_count), .fifo_level(w4_fifo_level), .busy(w4_busy)
    );

    int       checks = 0;
    int       failures = 0;
    int       reinit_seen = 0;
    bit       last_x;
    int       m_mode;
    int       m_cnt;
    bit [7:0] q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Entered at posedge+1 with inputs set; compares, advances the model, returns at next posedge+1.
    task automatic cycle();
        bit e_ctr;
        bit e_x;
        #4;
        e_ctr = (m_mode == M_RUN) && ks_valid && (q.size() < int'(DEPTH));
        e_x   = ct_valid && e_ctr;
        chk("ct_ready",   int'(ct_ready),   int'(e_ctr));
        chk("ks_ready",   int'(ks_ready),   int'(e_x));
        chk("ks_reinit",  int'(ks_reinit),  int'(m_mode == M_REINIT));
        chk("busy",       int'(busy),       int'(m_mode != M_RUN));
        chk("pt_valid",   int'(pt_valid),   int'(q.size() > 0));
        chk("pt_data",    int'(pt_data),    (q.size() > 0) ? int'(q[0]) : 0);
        chk("fifo_level", int'(fifo_level), q.size());
        chk("byte_count", int'(byte_count), m_cnt);
        chk("w4_count",   int'(w4_byte_count), m_cnt % 16);
        if (ks_reinit) reinit_seen++;
        last_x = e_x;
        if (rst) begin
            q.delete();
            m_cnt  = 0;
            m_mode = M_WAIT;
        end else begin
            if (pt_ready && q.size() > 0) void'(q.pop_front());
            if (e_x) q.push_back(ct_data ^ ks_byte);
            if (m_mode == M_REINIT) m_cnt = 0;
            else if (e_x) m_cnt = (m_cnt + 1) % 65536;
            if (resync) m_mode = M_REINIT;
            else if (m_mode == M_REINIT) m_mode = M_WAIT;
            else if (m_mode == M_WAIT && ks_valid) m_mode = M_RUN;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; ct_valid = 1'b0; resync = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    typedef struct {
        bit       ct_valid;
        bit [7:0] ct;
        bit       ks_valid;
        bit [7:0] ks;
        bit       pt_ready;
        bit       resync;
        bit       e_ctr;
        bit       e_ksr;
        bit       e_reinit;
        bit       e_ptv;
        bit [7:0] e_ptd;
        int       e_cnt;
        int       e_lvl;
        bit       e_busy;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int idx;
        int popped;

        vecs[0] = '{1'b0, 8'h00, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0, 1'b1};
        vecs[1] = '{1'b1, 8'h41, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 0, 0, 1'b0};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h1B, 1, 1, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1, 0, 1'b0};
        vecs[4] = '{1'b1, 8'h00, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1, 0, 1'b0};
        vecs[5] = '{1'b1, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 2, 1, 1'b1};
        vecs[6] = '{1'b1, 8'h00, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 0, 1, 1'b1};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0, 1'b1};
        vecs[8] = '{1'b1, 8'h12, 1'b1, 8'h34, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 0, 0, 1'b0};
        vecs[9] = '{1'b0, 8'h00, 1'b1, 8'h34, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h26, 1, 1, 1'b0};

        rst = 1'b1; ct_data = '0; ct_valid = 1'b0; ks_byte = '0; ks_valid = 1'b0;
        resync = 1'b0; pt_ready = 1'b0;
        m_mode = M_WAIT; m_cnt = 0; q.delete();
        repeat (2) @(posedge clk);
        #1;

        // Vector table: basic decrypt and a resync overlapping a transfer.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            ct_valid = vecs[i].ct_valid; ct_data = vecs[i].ct;
            ks_valid = vecs[i].ks_valid; ks_byte = vecs[i].ks;
            pt_ready = vecs[i].pt_ready; resync  = vecs[i].resync;
            #2;
            chk("tv_ct_ready",  int'(ct_ready),   int'(vecs[i].e_ctr));
            chk("tv_ks_ready",  int'(ks_ready),   int'(vecs[i].e_ksr));
            chk("tv_ks_reinit", int'(ks_reinit),  int'(vecs[i].e_reinit));
            chk("tv_pt_valid",  int'(pt_valid),   int'(vecs[i].e_ptv));
            chk("tv_pt_data",   int'(pt_data),    int'(vecs[i].e_ptd));
            chk("tv_count",     int'(byte_count), vecs[i].e_cnt);
            chk("tv_level",     int'(fifo_level), vecs[i].e_lvl);
            chk("tv_busy",      int'(busy),       int'(vecs[i].e_busy));
            cycle();
        end
        resync = 1'b0;

        // Fill to full with the consumer stalled, then drain in order.
        do_reset();
        ks_valid = 1'b1; ks_byte = 8'hFF; pt_ready = 1'b0; ct_valid = 1'b0;
        cycle();
        idx = 0;
        for (int i = 0; i < 12; i++) begin
            ct_valid = (idx < 9); ct_data = 8'(idx);
            cycle();
            if (last_x) idx++;
        end
        chk("full_level", int'(fifo_level), 8);
        chk("full_ct_ready", int'(ct_ready), 0);
        chk("full_count", int'(byte_count), 8);
        pt_ready = 1'b1; popped = 0;
        for (int i = 0; i < 20; i++) begin
            ct_valid = (idx < 9); ct_data = 8'(idx);
            if (pt_valid) begin
                chk("drain_order", int'(pt_data), int'(8'hFF ^ 8'(popped)));
                popped++;
            end
            cycle();
            if (last_x) idx++;
        end
        chk("drain_total", popped, 9);
        chk("drain_count", int'(byte_count), 9);

        // Keystream stall mid-stream freezes the count.
        do_reset();
        ks_valid = 1'b1; pt_ready = 1'b1; ct_valid = 1'b0;
        cycle();
        ct_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin ct_data = 8'($urandom); ks_byte = 8'($urandom); cycle(); end
        ks_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin ct_data = 8'($urandom); cycle(); end
        chk("stall_count", int'(byte_count), 4);
        ks_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin ct_data = 8'($urandom); ks_byte = 8'($urandom); cycle(); end
        chk("resume_count", int'(byte_count), 8);

        // Resync with two bytes still buffered.
        do_reset();
        ks_valid = 1'b1; pt_ready = 1'b0; ct_valid = 1'b0;
        cycle();
        ct_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin ct_data = 8'(8'h30 + i); ks_byte = 8'h0F; cycle(); end
        ct_valid = 1'b0; pt_ready = 1'b1;
        repeat (3) cycle();
        chk("pre_resync_level", int'(fifo_level), 2);
        reinit_seen = 0;
        resync = 1'b1;
        cycle();
        resync = 1'b0; ks_valid = 1'b0; ct_valid = 1'b1;
        repeat (4) cycle();
        chk("reinit_pulses", reinit_seen, 1);
        chk("resync_count", int'(byte_count), 0);
        chk("resync_drained", int'(fifo_level), 0);
        chk("resync_ct_ready", int'(ct_ready), 0);
        ks_valid = 1'b1;
        repeat (3) cycle();
        chk("resync_resume", int'(byte_count), 2);

        // 17 bytes: the 4-bit counter instance wraps 15 -> 0 -> 1.
        do_reset();
        ks_valid = 1'b1; pt_ready = 1'b1; ct_valid = 1'b0;
        cycle();
        ct_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin ct_data = 8'($urandom); ks_byte = 8'($urandom); cycle(); end
        chk("wrap_w4_count", int'(w4_byte_count), 1);
        chk("wrap_count", int'(byte_count), 17);

        // Reset in RUN with three bytes buffered.
        do_reset();
        ks_valid = 1'b1; pt_ready = 1'b0; ct_valid = 1'b0;
        cycle();
        ct_valid = 1'b1;
        repeat (3) cycle();
        ct_valid = 1'b0;
        chk("prerst_level", int'(fifo_level), 3);
        reinit_seen = 0;
        rst = 1'b1;
        cycle();
        rst = 1'b0; ks_valid = 1'b0;
        #1;
        chk("rst_pt_valid", int'(pt_valid), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_count", int'(byte_count), 0);
        chk("rst_busy", int'(busy), 1);
        cycle();
        chk("rst_no_reinit", reinit_seen, 0);

        // Randomised traffic with occasional resync and reset.
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 299) == 0);
            resync   = ($urandom_range(0, 79) == 0);
            ks_valid = ($urandom_range(0, 9) != 0);
            ct_valid = ($urandom_range(0, 2) != 0);
            pt_ready = ($urandom_range(0, 3) != 0);
            ct_data  = 8'($urandom);
            ks_byte  = 8'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
